// File: rtl/tri_csa_acc.sv
// rtl/tri_csa_acc.sv - carry-save operand-pair accumulator with one-cycle resolve and held result
module tri_csa_acc #(
  parameter int WIDTH  = 32,
  parameter int CNT_W  = 8,
  parameter int STICKY = 0
) (
  input  logic             nclk,
  input  logic             rst_b,
  input  logic             in_val,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             in_rdy,
  input  logic             clr,
  input  logic             rd_req,
  output logic             out_val,
  output logic [WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0] out_cnt,
  input  logic             out_ack
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_RES  = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_s;
  logic [WIDTH-1:0] r_c;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_ocnt;

  logic             w_accept;
  logic             w_clear;
  logic [WIDTH-1:0] w_s1;
  logic [WIDTH-1:0] w_m1;
  logic [WIDTH-1:0] w_c1;
  logic [WIDTH-1:0] w_s2;
  logic [WIDTH-1:0] w_m2;
  logic [WIDTH-1:0] w_c2;
  logic [CNT_W-1:0] w_cnt_inc;

  assign in_rdy   = (r_state == ST_IDLE) || (r_state == ST_ACC);
  assign out_val  = (r_state == ST_OUT);
  assign out_sum  = r_sum;
  assign out_cnt  = r_ocnt;
  assign w_accept = in_val & in_rdy;

  // 4:2 compression as two chained 3:2 rows; the left shift drops the MSB carry.
  assign w_s1 = r_s ^ r_c ^ in_a;
  assign w_m1 = (r_s & r_c) | (r_s & in_a) | (r_c & in_a);
  assign w_c1 = w_m1 << 1;
  assign w_s2 = w_s1 ^ w_c1 ^ in_b;
  assign w_m2 = (w_s1 & w_c1) | (w_s1 & in_b) | (w_c1 & in_b);
  assign w_c2 = w_m2 << 1;

  assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

  always_comb begin
    w_next  = r_state;
    w_clear = 1'b0;
    if (clr) begin
      w_next  = ST_IDLE;
      w_clear = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (rd_req)        w_next = ST_RES;
          else if (w_accept) w_next = ST_ACC;
        end
        ST_ACC: begin
          if (rd_req) w_next = ST_RES;
        end
        ST_RES: w_next = ST_OUT;
        ST_OUT: begin
          if (out_ack) begin
            if (STICKY != 0) begin
              w_next = ST_ACC;
            end else begin
              w_next  = ST_IDLE;
              w_clear = 1'b1;
            end
          end
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge nclk) begin
    if (!rst_b) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge nclk) begin
    if (!rst_b) begin
      r_s    <= '0;
      r_c    <= '0;
      r_cnt  <= '0;
      r_sum  <= '0;
      r_ocnt <= '0;
    end else begin
      if (w_clear) begin
        r_s   <= '0;
        r_c   <= '0;
        r_cnt <= '0;
      end else if (w_accept) begin
        r_s   <= w_s2;
        r_c   <= w_c2;
        r_cnt <= w_cnt_inc;
      end
      // The only carry-propagate add, used once per read.
      if (!clr && (r_state == ST_RES)) begin
        r_sum  <= r_s + r_c;
        r_ocnt <= r_cnt;
      end
    end
  end

endmodule
